// File: rtl/edge_cacheline_unpacker.sv
// edge_cacheline_unpacker
//   Accepts one read-response cacheline at a time and streams the edge
//   entries it holds, starting at a given edge offset, one per handshake.
//   Byte k of the line sits at bits [LINE_W-1-8k -: 8]; within an emitted
//   edge the lowest-addressed byte is the least significant.
//
// Ports
//   clock, rstn        clock (rising edge) and async active-low reset
//   enabled_in         unit enable; low blocks acceptance of new lines
//   line_in_*          cacheline offer: valid/ready, data, first edge offset,
//                      edge count (0..CACHELINE_EDGE_NUM)
//   edge_out_*         edge stream: valid/ready, data, last-of-line flag
//   edges_emitted      free-running count of edge handshakes
//   clamp_error        sticky: a line asked for edges past the end of line
module edge_cacheline_unpacker #(
   parameter int unsigned CACHELINE_SIZE = 128,
   parameter int unsigned EDGE_SIZE      = 4
) (
   input  logic                                                 clock,
   input  logic                                                 rstn,
   input  logic                                                 enabled_in,
   input  logic                                                 line_in_valid,
   input  logic [CACHELINE_SIZE*8-1:0]                          line_in_data,
   input  logic [$clog2(CACHELINE_SIZE/EDGE_SIZE)-1:0]          line_in_offset,
   input  logic [$clog2(CACHELINE_SIZE/EDGE_SIZE+1)-1:0]        line_in_count,
   output logic                                                 line_in_ready,
   output logic                                                 edge_out_valid,
   output logic [EDGE_SIZE*8-1:0]                               edge_out_data,
   output logic                                                 edge_out_last,
   input  logic                                                 edge_out_ready,
   output logic [31:0]                                          edges_emitted,
   output logic                                                 clamp_error
);

   localparam int unsigned CACHELINE_EDGE_NUM = CACHELINE_SIZE / EDGE_SIZE;
   localparam int unsigned LINE_W = CACHELINE_SIZE * 8;
   localparam int unsigned EDGE_W = EDGE_SIZE * 8;
   localparam int unsigned IDX_W  = $clog2(CACHELINE_EDGE_NUM);
   localparam int unsigned CNT_W  = $clog2(CACHELINE_EDGE_NUM + 1);
   localparam logic [CNT_W-1:0] NUM_C = CNT_W'(CACHELINE_EDGE_NUM);

   typedef enum logic [0:0] {IDLE, DRAIN} state_t;

   state_t             state_q, state_d;
   logic [LINE_W-1:0]  line_q;
   logic [IDX_W-1:0]   idx_q;
   logic [CNT_W-1:0]   rem_q;
   logic [CNT_W-1:0]   avail;
   logic [CNT_W-1:0]   eff_count;
   logic               clamp;
   logic               accept;
   logic               load;
   logic               handshake;
   logic [EDGE_W-1:0]  edge_word [CACHELINE_EDGE_NUM];

   // Static byte-order remap of the stored line into edge words, so the
   // output path is a plain word select by idx.
   for (genvar e = 0; e < CACHELINE_EDGE_NUM; e++) begin : g_edge
      for (genvar b = 0; b < EDGE_SIZE; b++) begin : g_byte
         assign edge_word[e][8*b +: 8] = line_q[LINE_W-1-8*(EDGE_SIZE*e+b) -: 8];
      end
   end

   // Edges available from the offset to the end of the line (always >= 1).
   assign avail     = NUM_C - CNT_W'(line_in_offset);
   assign clamp     = line_in_count > avail;
   assign eff_count = clamp ? avail : line_in_count;
   assign accept    = line_in_valid && line_in_ready;
   assign load      = accept && (line_in_count != '0);
   assign handshake = edge_out_valid && edge_out_ready;

   // State register
   always_ff @(posedge clock or negedge rstn) begin
      if (!rstn) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (load) state_d = DRAIN;
         DRAIN:   if (handshake && rem_q == CNT_W'(1)) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Output logic; rstn gates ready so it reads 0 throughout reset.
   always_comb begin
      line_in_ready  = rstn && (state_q == IDLE) && enabled_in;
      edge_out_valid = (state_q == DRAIN);
      edge_out_last  = (state_q == DRAIN) && (rem_q == CNT_W'(1));
      edge_out_data  = (state_q == DRAIN) ? edge_word[idx_q] : '0;
   end

   // Control counters and status
   always_ff @(posedge clock or negedge rstn) begin
      if (!rstn) begin
         idx_q         <= '0;
         rem_q         <= '0;
         edges_emitted <= '0;
         clamp_error   <= 1'b0;
      end else begin
         if (load) begin
            idx_q <= line_in_offset;
            rem_q <= eff_count;
            if (clamp) clamp_error <= 1'b1;
         end else if (handshake) begin
            idx_q <= idx_q + IDX_W'(1);
            rem_q <= rem_q - CNT_W'(1);
         end
         if (handshake) edges_emitted <= edges_emitted + 32'd1;
      end
   end

   // Line payload; only meaningful in DRAIN, so it carries no reset.
   always_ff @(posedge clock) begin
      if (load) line_q <= line_in_data;
   end

endmodule

// File: tb/tb_edge_cacheline_unpacker.sv
module tb_edge_cacheline_unpacker;

   logic          clock;
   logic          rstn;
   logic          enabled_in;
   logic          line_in_valid;
   logic [1023:0] line_in_data;
   logic [4:0]    line_in_offset;
   logic [5:0]    line_in_count;
   logic          line_in_ready;
   logic          edge_out_valid;
   logic [31:0]   edge_out_data;
   logic          edge_out_last;
   logic          edge_out_ready;
   logic [31:0]   edges_emitted;
   logic          clamp_error;

   int unsigned n_cmp = 0;
   int unsigned n_err = 0;
   logic [31:0] exp_cnt = 32'd0;

   edge_cacheline_unpacker #(
      .CACHELINE_SIZE(128),
      .EDGE_SIZE     (4)
   ) dut (
      .clock         (clock),
      .rstn          (rstn),
      .enabled_in    (enabled_in),
      .line_in_valid (line_in_valid),
      .line_in_data  (line_in_data),
      .line_in_offset(line_in_offset),
      .line_in_count (line_in_count),
      .line_in_ready (line_in_ready),
      .edge_out_valid(edge_out_valid),
      .edge_out_data (edge_out_data),
      .edge_out_last (edge_out_last),
      .edge_out_ready(edge_out_ready),
      .edges_emitted (edges_emitted),
      .clamp_error   (clamp_error)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Byte k of the line holds k ^ xr.
   function automatic logic [1023:0] make_line(input logic [7:0] xr);
      logic [1023:0] l;
      l = '0;
      for (int k = 0; k < 128; k++) l[1023-8*k -: 8] = 8'(k) ^ xr;
      return l;
   endfunction

   function automatic logic [31:0] exp_edge(input logic [7:0] xr, input int i);
      return {8'(4*i+3) ^ xr, 8'(4*i+2) ^ xr, 8'(4*i+1) ^ xr, 8'(4*i) ^ xr};
   endfunction

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   // Offers a line for one edge; returns 1 time unit after the accepting edge.
   task automatic offer(input logic [7:0] xr, input int off, input int cnt);
      enabled_in     = 1'b1;
      line_in_valid  = 1'b1;
      line_in_data   = make_line(xr);
      line_in_offset = 5'(off);
      line_in_count  = 6'(cnt);
      step();
      line_in_valid  = 1'b0;
   endtask

   task automatic test_reset();
      rstn = 1'b0; enabled_in = 1'b1; line_in_valid = 1'b0; edge_out_ready = 1'b1;
      line_in_data = '0; line_in_offset = '0; line_in_count = '0;
      #2;
      repeat (2) begin
         n_cmp++;
         if ({line_in_ready, edge_out_valid, edge_out_last, edge_out_data, edges_emitted, clamp_error} !== 67'd0) begin
            n_err++;
            $display("FAIL reset_outputs: got rdy=%b v=%b l=%b d=%h cnt=%0d clamp=%b, want all 0",
                     line_in_ready, edge_out_valid, edge_out_last, edge_out_data, edges_emitted, clamp_error);
         end
         step();
      end
      rstn = 1'b1;
      #1;
      n_cmp++;
      if (line_in_ready !== 1'b1) begin
         n_err++; $display("FAIL reset_release_ready: got %b want 1", line_in_ready);
      end
   endtask

   task automatic test_full_line();
      offer(8'h00, 0, 32);
      for (int i = 0; i < 32; i++) begin
         n_cmp++;
         if (edge_out_valid !== 1'b1 || edge_out_data !== exp_edge(8'h00, i) ||
             edge_out_last !== (i == 31) || line_in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL full_edge%0d: got v=%b d=%h l=%b rdy=%b want v=1 d=%h l=%b rdy=0",
                     i, edge_out_valid, edge_out_data, edge_out_last, line_in_ready,
                     exp_edge(8'h00, i), (i == 31));
         end
         step();
      end
      exp_cnt += 32;
      n_cmp++;
      if (edge_out_valid !== 1'b0 || edges_emitted !== exp_cnt || line_in_ready !== 1'b1 || clamp_error !== 1'b0) begin
         n_err++;
         $display("FAIL full_end: got v=%b cnt=%0d rdy=%b clamp=%b want v=0 cnt=%0d rdy=1 clamp=0",
                  edge_out_valid, edges_emitted, line_in_ready, clamp_error, exp_cnt);
      end
   endtask

   task automatic test_clamp();
      offer(8'h00, 30, 5);
      for (int i = 0; i < 2; i++) begin
         n_cmp++;
         if (edge_out_valid !== 1'b1 || edge_out_data !== exp_edge(8'h00, 30 + i) || edge_out_last !== (i == 1)) begin
            n_err++;
            $display("FAIL clamp_edge%0d: got v=%b d=%h l=%b want v=1 d=%h l=%b",
                     i, edge_out_valid, edge_out_data, edge_out_last, exp_edge(8'h00, 30 + i), (i == 1));
         end
         step();
      end
      exp_cnt += 2;
      n_cmp++;
      if (edge_out_valid !== 1'b0 || clamp_error !== 1'b1 || edges_emitted !== exp_cnt) begin
         n_err++;
         $display("FAIL clamp_end: got v=%b clamp=%b cnt=%0d want v=0 clamp=1 cnt=%0d",
                  edge_out_valid, clamp_error, edges_emitted, exp_cnt);
      end
   endtask

   task automatic test_zero_count();
      offer(8'h77, 5, 0);
      n_cmp++;
      if (edge_out_valid !== 1'b0 || line_in_ready !== 1'b1 || edges_emitted !== exp_cnt) begin
         n_err++;
         $display("FAIL zero_count: got v=%b rdy=%b cnt=%0d want v=0 rdy=1 cnt=%0d",
                  edge_out_valid, line_in_ready, edges_emitted, exp_cnt);
      end
      step();
      n_cmp++;
      if (edge_out_valid !== 1'b0) begin
         n_err++; $display("FAIL zero_count_later: got v=%b want 0", edge_out_valid);
      end
   endtask

   task automatic test_stall();
      int got;
      int c;
      got = 0;
      c = 0;
      offer(8'h5A, 3, 4);
      while (got < 4 && c < 30) begin
         edge_out_ready = ((c % 3) == 0);
         n_cmp++;
         if (edge_out_valid !== 1'b1 || edge_out_data !== exp_edge(8'h5A, 3 + got) || edge_out_last !== (got == 3)) begin
            n_err++;
            $display("FAIL stall_cyc%0d: got v=%b d=%h l=%b want v=1 d=%h l=%b",
                     c, edge_out_valid, edge_out_data, edge_out_last, exp_edge(8'h5A, 3 + got), (got == 3));
         end
         if (edge_out_ready) got++;
         step();
         c++;
      end
      edge_out_ready = 1'b1;
      exp_cnt += 4;
      n_cmp++;
      if (got != 4 || edge_out_valid !== 1'b0 || edges_emitted !== exp_cnt) begin
         n_err++;
         $display("FAIL stall_end: got edges=%0d v=%b cnt=%0d want edges=4 v=0 cnt=%0d",
                  got, edge_out_valid, edges_emitted, exp_cnt);
      end
   endtask

   task automatic test_back_to_back();
      offer(8'h11, 10, 2);
      // Line B held on the input throughout line A's drain.
      line_in_valid = 1'b1; line_in_data = make_line(8'h22);
      line_in_offset = 5'd20; line_in_count = 6'd1;
      for (int i = 0; i < 2; i++) begin
         n_cmp++;
         if (edge_out_valid !== 1'b1 || edge_out_data !== exp_edge(8'h11, 10 + i) ||
             edge_out_last !== (i == 1) || line_in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_a%0d: got v=%b d=%h l=%b rdy=%b want v=1 d=%h l=%b rdy=0",
                     i, edge_out_valid, edge_out_data, edge_out_last, line_in_ready, exp_edge(8'h11, 10 + i), (i == 1));
         end
         step();
      end
      n_cmp++;
      if (edge_out_valid !== 1'b0 || line_in_ready !== 1'b1) begin
         n_err++; $display("FAIL b2b_gap: got v=%b rdy=%b want v=0 rdy=1", edge_out_valid, line_in_ready);
      end
      step();
      line_in_valid = 1'b0;
      n_cmp++;
      if (edge_out_valid !== 1'b1 || edge_out_data !== exp_edge(8'h22, 20) || edge_out_last !== 1'b1) begin
         n_err++;
         $display("FAIL b2b_b: got v=%b d=%h l=%b want v=1 d=%h l=1",
                  edge_out_valid, edge_out_data, edge_out_last, exp_edge(8'h22, 20));
      end
      step();
      exp_cnt += 3;
      n_cmp++;
      if (edge_out_valid !== 1'b0 || edges_emitted !== exp_cnt) begin
         n_err++;
         $display("FAIL b2b_end: got v=%b cnt=%0d want v=0 cnt=%0d", edge_out_valid, edges_emitted, exp_cnt);
      end
   endtask

   task automatic test_enable_hold();
      enabled_in = 1'b0; line_in_valid = 1'b1; line_in_data = make_line(8'h3C);
      line_in_offset = 5'd7; line_in_count = 6'd1;
      for (int i = 0; i < 3; i++) begin
         #1;
         n_cmp++;
         if (line_in_ready !== 1'b0 || edge_out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL enable_hold%0d: got rdy=%b v=%b want rdy=0 v=0", i, line_in_ready, edge_out_valid);
         end
         step();
      end
      enabled_in = 1'b1;
      #1;
      n_cmp++;
      if (line_in_ready !== 1'b1) begin
         n_err++; $display("FAIL enable_raise: got rdy=%b want 1", line_in_ready);
      end
      step();
      line_in_valid = 1'b0;
      n_cmp++;
      if (edge_out_valid !== 1'b1 || edge_out_data !== exp_edge(8'h3C, 7) || edge_out_last !== 1'b1) begin
         n_err++;
         $display("FAIL enable_edge: got v=%b d=%h l=%b want v=1 d=%h l=1",
                  edge_out_valid, edge_out_data, edge_out_last, exp_edge(8'h3C, 7));
      end
      step();
      exp_cnt += 1;
   endtask

   task automatic test_enable_drain();
      offer(8'h44, 0, 3);
      enabled_in = 1'b0;
      for (int i = 0; i < 3; i++) begin
         n_cmp++;
         if (edge_out_valid !== 1'b1 || edge_out_data !== exp_edge(8'h44, i)) begin
            n_err++;
            $display("FAIL en_drain%0d: got v=%b d=%h want v=1 d=%h", i, edge_out_valid, edge_out_data, exp_edge(8'h44, i));
         end
         step();
      end
      exp_cnt += 3;
      n_cmp++;
      if (edge_out_valid !== 1'b0 || line_in_ready !== 1'b0 || edges_emitted !== exp_cnt) begin
         n_err++;
         $display("FAIL en_drain_end: got v=%b rdy=%b cnt=%0d want v=0 rdy=0 cnt=%0d",
                  edge_out_valid, line_in_ready, edges_emitted, exp_cnt);
      end
      enabled_in = 1'b1;
   endtask

   task automatic test_reset_mid_drain();
      offer(8'h00, 0, 8);
      step();
      step();
      rstn = 1'b0;
      #1;
      n_cmp++;
      if ({line_in_ready, edge_out_valid, edge_out_last, edge_out_data, edges_emitted, clamp_error} !== 67'd0) begin
         n_err++;
         $display("FAIL mid_reset: got rdy=%b v=%b l=%b d=%h cnt=%0d clamp=%b want all 0",
                  line_in_ready, edge_out_valid, edge_out_last, edge_out_data, edges_emitted, clamp_error);
      end
      step();
      rstn = 1'b1;
      for (int i = 0; i < 2; i++) begin
         step();
         n_cmp++;
         if (edge_out_valid !== 1'b0) begin
            n_err++; $display("FAIL post_reset_idle%0d: got v=%b want 0", i, edge_out_valid);
         end
      end
      offer(8'h33, 1, 2);
      for (int i = 0; i < 2; i++) begin
         n_cmp++;
         if (edge_out_valid !== 1'b1 || edge_out_data !== exp_edge(8'h33, 1 + i) || edge_out_last !== (i == 1)) begin
            n_err++;
            $display("FAIL post_reset_edge%0d: got v=%b d=%h l=%b want v=1 d=%h l=%b",
                     i, edge_out_valid, edge_out_data, edge_out_last, exp_edge(8'h33, 1 + i), (i == 1));
         end
         step();
      end
      n_cmp++;
      if (edge_out_valid !== 1'b0 || edges_emitted !== 32'd2) begin
         n_err++;
         $display("FAIL post_reset_cnt: got v=%b cnt=%0d want v=0 cnt=2", edge_out_valid, edges_emitted);
      end
   endtask

   initial begin
      test_reset();
      test_full_line();
      test_clamp();
      test_zero_count();
      test_stall();
      test_back_to_back();
      test_enable_hold();
      test_enable_drain();
      test_reset_mid_drain();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/edge_cacheline_unpacker.md
EDGE_CACHELINE_UNPACKER -- requirements
Module: edge_cacheline_unpacker

Interface
REQ-001 SHALL have parameter CACHELINE_SIZE, default 128, meaning bytes per read-response cacheline.
REQ-002 SHALL have parameter EDGE_SIZE, default 4, meaning bytes per edge entry; CACHELINE_EDGE_NUM = CACHELINE_SIZE/EDGE_SIZE = 32.
REQ-003 SHALL have ports, listed here as name, direction, width, meaning:
- clock  in  1  single clock; all state updates on its rising edge.
- rstn  in  1  asynchronous active-low reset.
- enabled_in  in  1  unit enable; low blocks acceptance of new cachelines.
- line_in_valid  in  1  cacheline offered.
- line_in_data  in  1024  cacheline payload; byte k = bits [1023-8k : 1016-8k].
- line_in_offset  in  5  index of first valid edge in line.
- line_in_count  in  6  number of edges to emit, 0..32.
- line_in_ready  out  1  unpacker can accept a cacheline.
- edge_out_valid  out  1  edge presented.
- edge_out_data  out  32  edge value.
- edge_out_last  out  1  final edge of current cacheline.
- edge_out_ready  in  1  downstream accepts edge.
- edges_emitted  out  32  running count of edge handshakes.
- clamp_error  out  1  sticky flag; offset+count exceeded 32.

Function
REQ-004 SHALL implement FSM states IDLE and DRAIN.
REQ-005 line_in_ready SHALL equal 1 only in IDLE with enabled_in=1; a cacheline is accepted on a cycle where line_in_valid and line_in_ready are both 1.
REQ-006 On acceptance with line_in_count>0, SHALL register the data, set idx=line_in_offset, rem=effective count, and move to DRAIN.
REQ-007 On acceptance with line_in_count=0, SHALL drop the line and stay in IDLE; no edge is emitted.
REQ-008 Effective count SHALL be min(line_in_count, 32-line_in_offset); when clamping occurs, clamp_error SHALL set to 1 and hold until reset.
REQ-009 In DRAIN, edge_out_valid SHALL be 1; edge_out_data SHALL be bytes 4*idx..4*idx+3 of the stored line, with byte 4*idx the least significant.
REQ-010 First edge_out_valid SHALL assert the cycle after acceptance (latency 1); with edge_out_ready held at 1, SHALL emit one edge per cycle.
REQ-011 edge_out_last SHALL be 1 exactly when rem=1 in DRAIN.
REQ-012 On each edge handshake, SHALL increment idx and decrement rem and increment edges_emitted (wrapping modulo 2^32); on the handshake with rem=1, SHALL return to IDLE.
REQ-013 While edge_out_valid=1 and edge_out_ready=0, edge_out_data and edge_out_last SHALL stay stable.
REQ-014 line_in_ready SHALL be 0 throughout DRAIN, including the final-handshake cycle; back-to-back lines therefore cost one IDLE cycle.
REQ-015 Deasserting enabled_in during DRAIN SHALL NOT abort the drain; only new acceptance is blocked.
REQ-016 Stored data SHALL be updated only on acceptance.

Reset
REQ-017 While rstn=0, regardless of clock: state=IDLE; idx, rem, edges_emitted, clamp_error, edge_out_valid, edge_out_last, edge_out_data and line_in_ready SHALL all be 0.
REQ-018 Reset asserted mid-DRAIN SHALL discard the remaining edges; no edge SHALL be emitted after reset releases until a new line is accepted.

Verification
REQ-019 Accept a line with offset=0, count=32, edge_out_ready=1 -> 32 edges on consecutive cycles starting the cycle after acceptance; last is high on edge 32; edges_emitted=32.
REQ-020 Accept a line with offset=30, count=5 -> 2 edges (idx 30, 31) and clamp_error=1; last on the second edge.
REQ-021 Accept a line with count=0 -> no edge_out_valid; line_in_ready is 1 again the next cycle; edges_emitted is unchanged.
REQ-022 Accept a line with offset=3, count=4; toggle edge_out_ready 1,0,0,1,... -> data is stable during stalls; edges are emitted in byte-order words 3..6 exactly once each.
REQ-023 Reset during DRAIN after 2 of 8 edges -> all outputs are 0 immediately; the next line starts cleanly; edges_emitted restarts from 0.
REQ-024 Hold enabled_in=0 while line_in_valid=1 -> line_in_ready stays 0 and no acceptance occurs; raising enabled_in gives acceptance that cycle.
